// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Round-robin arbiter sharing one memory port between instruction
//               fetch and data load/store; registers read data for the
//               datapath. Optional access timeout enabled by MEM_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_ack,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          busy,
  output logic          timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          last_dm_q, last_dm_d;
  logic          grant_dm_q, grant_dm_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          if_ack_q, if_ack_d;
  logic          dm_ack_q, dm_ack_d;
  logic          busy_q, busy_d;
  logic          pick_dm;
  logic          finish;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] C_CNT_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_q, tmo_d;
`endif

  // DM wins only when IF is idle or IF was the previous winner.
  assign pick_dm = dm_req & (~if_req | ~last_dm_q);

  always_comb begin
    state_d     = state_q;
    last_dm_d   = last_dm_q;
    grant_dm_d  = grant_dm_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    busy_d      = 1'b0;
    finish      = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d = cnt_q;
    tmo_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (if_req | dm_req) begin
          state_d    = ST_ACCESS;
          last_dm_d  = pick_dm;
          grant_dm_d = pick_dm;
          mem_en_d   = 1'b1;
          busy_d     = 1'b1;
          if (pick_dm) begin
            mem_addr_d  = dm_addr;
            mem_we_d    = dm_we;
            mem_wdata_d = dm_wdata;
          end else begin
            mem_addr_d = if_addr;
            mem_we_d   = 1'b0;
          end
`ifdef MEM_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end
      ST_ACCESS: begin
        mem_en_d = 1'b1;
        busy_d   = 1'b1;
        if (mem_ready) begin
          if (!mem_we_q) rdata_d = mem_rdata;
          finish = 1'b1;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == C_CNT_LAST) begin
          finish = 1'b1;
          tmo_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
        if (finish) begin
          state_d  = ST_DONE;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          if_ack_d = ~grant_dm_q;
          dm_ack_d = grant_dm_q;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      last_dm_q   <= 1'b1;
      grant_dm_q  <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_dm_q   <= last_dm_d;
      grant_dm_q  <= grant_dm_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      busy_q      <= busy_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end
  assign timeout_err = tmo_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign rdata     = rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire
